// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - round-robin scheduler sharing one up counter between two requesters
//
// Purpose:
//   Arbitrates two requesters for a single WIDTH-bit up counter. The winner's
//   start value is loaded into the counter. Counting is then enabled until the
//   counter output equals the winner's terminal value, and a one-cycle DONE
//   pulse goes back to the winner. If the granted requester drops REQ before
//   completion, the run is abandoned and ABORTED pulses for one cycle.
//
// Optional feature (macro COUNTER_SCHED_WDOG_EN):
//   Adds a RUN-state watchdog. After 2^WIDTH+2 RUN cycles without a terminal
//   match, the run is abandoned, and ABORTED and TIMEOUT both pulse for one cycle.
//
// Ports:
//   CLOCK       in   system clock, rising edge
//   RESET       in   asynchronous active-low reset; also clears the counter
//   REQ         in   [1:0] level requests, held until DONE
//   REQ_START   in   [2*WIDTH-1:0] start values, requester i at [i*WIDTH +: WIDTH]
//   REQ_TERM    in   [2*WIDTH-1:0] terminal values, same packing
//   GNT         out  [1:0] one-hot grant, LOAD through FIN
//   DONE        out  [1:0] one-cycle completion pulse
//   ABORTED     out  one-cycle pulse on requester drop (or watchdog expiry)
//   BUSY        out  high whenever not IDLE
//   CNT_ENABLE  out  counter ENABLE
//   CNT_LOAD    out  counter LOAD
//   CNT_DATA    out  [WIDTH-1:0] counter DATA
//   CNT_COUNT   in   [WIDTH-1:0] counter COUNT
//   TIMEOUT     out  one-cycle watchdog pulse (only with COUNTER_SCHED_WDOG_EN)

module counter_sched #(
  parameter int WIDTH = 8
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic [1:0]         REQ,
  input  logic [2*WIDTH-1:0] REQ_START,
  input  logic [2*WIDTH-1:0] REQ_TERM,
  output logic [1:0]         GNT,
  output logic [1:0]         DONE,
  output logic               ABORTED,
  output logic               BUSY,
  output logic               CNT_ENABLE,
  output logic               CNT_LOAD,
  output logic [WIDTH-1:0]   CNT_DATA,
  input  logic [WIDTH-1:0]   CNT_COUNT
`ifdef COUNTER_SCHED_WDOG_EN
  ,
  output logic               TIMEOUT
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_winner;
  logic             r_last;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_term;
  logic             r_aborted;

  logic             w_pick;
  logic             w_req_win;
  logic             w_term_hit;
  logic             w_abort;
  logic             w_timeout;
  logic [1:0]       w_onehot;

  // When both requesters ask, the one not served last wins.
  assign w_pick     = (REQ == 2'b11) ? ~r_last : REQ[1];
  assign w_req_win  = r_winner ? REQ[1] : REQ[0];
  assign w_term_hit = (CNT_COUNT == r_term);
  assign w_abort    = ((r_state == S_LOAD) || (r_state == S_RUN)) && !w_req_win;
  assign w_onehot   = {r_winner, ~r_winner};

`ifdef COUNTER_SCHED_WDOG_EN
  localparam logic [WIDTH+1:0] WDOG_LAST = {2'b01, {WIDTH{1'b0}}} + 1'b1;

  logic [WIDTH+1:0] r_wdog;
  logic             r_timeout;

  // The watchdog holds WDOG_LAST during the final allowed RUN cycle. Expiry
  // therefore lands on the edge that would complete 2^WIDTH+2 RUN cycles.
  assign w_timeout = (r_state == S_RUN) && !w_abort && !w_term_hit && (r_wdog == WDOG_LAST);
  assign TIMEOUT   = r_timeout;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      if (r_state == S_IDLE) begin
        r_wdog <= '0;
      end else if (r_state == S_RUN) begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (|REQ) w_next = S_LOAD;
      S_LOAD: w_next = w_abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (w_abort || w_timeout) begin
          w_next = S_IDLE;
        end else if (w_term_hit) begin
          w_next = S_FIN;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // An abort masks the counter controls in the same cycle, so the counter
  // freezes where it stands.
  always_comb begin
    CNT_ENABLE = 1'b0;
    CNT_LOAD   = 1'b0;
    CNT_DATA   = '0;
    GNT        = 2'b00;
    DONE       = 2'b00;
    BUSY       = (r_state != S_IDLE);
    ABORTED    = r_aborted;
    if (r_state != S_IDLE) GNT = w_onehot;
    case (r_state)
      S_LOAD: begin
        CNT_DATA   = r_start;
        CNT_LOAD   = !w_abort;
        CNT_ENABLE = !w_abort;
      end
      S_RUN:   CNT_ENABLE = !w_abort && !w_term_hit;
      S_FIN:   DONE = w_onehot;
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= S_IDLE;
      r_winner  <= 1'b0;
      r_last    <= 1'b1;
      r_start   <= '0;
      r_term    <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_aborted <= w_abort || w_timeout;
      if ((r_state == S_IDLE) && (|REQ)) begin
        r_winner <= w_pick;
        r_start  <= w_pick ? REQ_START[2*WIDTH-1:WIDTH] : REQ_START[WIDTH-1:0];
        r_term   <= w_pick ? REQ_TERM[2*WIDTH-1:WIDTH]  : REQ_TERM[WIDTH-1:0];
      end
      if ((r_state == S_FIN) || w_abort || w_timeout) begin
        r_last <= r_winner;
      end
    end
  end

endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Scheduler that shares one 8-bit up counter (ENABLE/LOAD/DATA/COUNT interface) between two requesters.
- Each requester asks for a run from a start value to a terminal value. The scheduler arbitrates round-robin, loads the start value, enables counting until COUNT equals the terminal value, then signals completion.
- Sits between the requesting control logic and the counter instance. Its RESET also feeds the counter's RESET.

Parameters:
WIDTH, 8, counter data width; sets width of CNT_DATA, CNT_COUNT and each start/terminal field.

Ports:
CLOCK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-low reset
REQ  input  2  per-requester run request, level; held until DONE
REQ_START  input  2*WIDTH  start values; requester i uses bits [i*WIDTH +: WIDTH]
REQ_TERM  input  2*WIDTH  terminal values; same packing
GNT  output  2  one-hot grant; high from LOAD through DONE
DONE  output  2  one-cycle completion pulse to the granted requester
ABORTED  output  1  one-cycle pulse when a granted requester drops REQ before completion
BUSY  output  1  high whenever state is not IDLE
CNT_ENABLE  output  1  to counter ENABLE
CNT_LOAD  output  1  to counter LOAD
CNT_DATA  output  WIDTH  to counter DATA
CNT_COUNT  input  WIDTH  from counter COUNT

Behaviour:
- Reset (RESET low, async): state IDLE; GNT=0, DONE=0, ABORTED=0, BUSY=0, CNT_ENABLE=0, CNT_LOAD=0, CNT_DATA=0; last_served=1, so requester 0 wins first.
- FSM states: IDLE, LOAD, RUN, FIN.
- IDLE:
  - If any REQ is high, pick the winner. Single requester wins outright. If both are high, the one not equal to last_served wins.
  - Latch the winner's START/TERM into internal registers; REQ_START/REQ_TERM are ignored after this edge.
  - Set GNT; go to LOAD.
- LOAD (1 cycle): CNT_ENABLE=1, CNT_LOAD=1, CNT_DATA=start_q. Counter loads at the next edge. Go to RUN.
- RUN:
  - CNT_LOAD=0.
  - CNT_ENABLE = (CNT_COUNT != term_q), combinational, so the counter stops exactly on term_q.
  - When CNT_COUNT == term_q, go to FIN.
- FIN (1 cycle): DONE[winner]=1, GNT held, CNT_ENABLE=0. Update last_served=winner; go to IDLE. GNT and BUSY drop at that edge.
- Arithmetic and edge cases:
  - Modulo 2^WIDTH. If term < start, the counter wraps (255→0) and continues; total increments = (term − start) mod 256.
  - term == start: zero increments; RUN lasts 1 cycle with CNT_ENABLE=0.
- Latency: REQ sampled at edge e → GNT after e. Load at e+1. n increments at edges e+2..e+n+1. FIN begins after edge e+n+2 (RUN lasts n+1 cycles). DONE is high for the cycle after edge e+n+2. Back in IDLE after e+n+3. A new grant can follow 1 IDLE cycle later.
- Abort: if REQ[winner] is low while in LOAD or RUN:
  - Next edge goes to IDLE with ABORTED=1 for one cycle, no DONE.
  - CNT_ENABLE/CNT_LOAD are forced 0 combinationally in that same cycle.
  - last_served=winner.
  - Counter value is left as is.
- REQ of the non-granted requester is ignored until IDLE. REQ changes during FIN have no effect.
- Reset mid-run: immediate return to IDLE, all outputs at reset values; the counter is also cleared by the shared RESET.

Optional Feature:
- Macro COUNTER_SCHED_WDOG_EN.
- Defined:
  - A WIDTH+2-bit watchdog counts cycles in RUN.
  - If it reaches 2^WIDTH+2 without term match, go to IDLE. Pulse ABORTED plus an extra output TIMEOUT (1 bit, one-cycle), no DONE.
  - The watchdog clears on entry to LOAD.
  - TIMEOUT resets to 0.
- Not defined: no watchdog and no TIMEOUT port; RUN waits indefinitely.

Test Plan:
- Req0 start=10 term=13, counter instantiated → CNT_LOAD one cycle with DATA=10; COUNT 10,11,12,13 then holds. DONE[0] pulses 1 cycle exactly 5 edges after the grant edge; GNT=01 until IDLE.
- Req1 start=254 term=2 → wraps 254,255,0,1,2; CNT_ENABLE low once COUNT=2; DONE[1] pulse.
- Both REQ high continuously, term=start+1 each → grants alternate 01,10,01,10. After reset, first grant = 01.
- start=term=77 → RUN 1 cycle with CNT_ENABLE=0; DONE pulse; COUNT stays 77.
- Req0 start=0 term=200, drop REQ[0] when COUNT=50 → ABORTED pulse, no DONE, COUNT stops at ≤51. Pending REQ[1] is granted next.
- RESET low mid-RUN → all outputs 0 asynchronously, COUNT=0. With COUNTER_SCHED_WDOG_EN, a counter stub held at 0 with term=5 → TIMEOUT and ABORTED pulse after 258 RUN cycles.
